// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding and sizing helper for serial_adder.
// Ports: none (package).
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic int cnt_w(input int w);
    int c;
    c = $clog2(w);
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/halfAdder.sv
// halfAdder: one-bit half adder cell.
// Ports: A, B operands; S sum; C carry.
module halfAdder (
  input  logic A,
  input  logic B,
  output logic S,
  output logic C
);

  assign S = A ^ B;
  assign C = A & B;

endmodule

// File: rtl/serial_adder_full_adder_bit.sv
// full_adder_bit: one-bit full adder from two halfAdder cells and an OR.
// Ports: a, b, ci inputs; s sum; co carry out.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s0;
  logic c0;
  logic c1;

  halfAdder u_ha0 (
    .A(a),
    .B(b),
    .S(s0),
    .C(c0)
  );

  halfAdder u_ha1 (
    .A(s0),
    .B(ci),
    .S(s),
    .C(c1)
  );

  assign co = c0 | c1;

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial W-bit adder, LSB first, valid/ready on both sides.
// Ports: clk, rst; in_valid/in_ready, a, b, cin; out_valid/out_ready, sum, cout; busy.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         busy
);

  localparam int CW = cnt_w(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_e        state_q, state_d;
  logic [W-1:0]  a_sh_q, a_sh_d;
  logic [W-1:0]  b_sh_q, b_sh_d;
  logic [W-1:0]  sum_sh_q, sum_sh_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          carry_q, carry_d;
  logic          cout_q, cout_d;
  logic [CW-1:0] count_q, count_d;

  logic fa_s;
  logic fa_co;

  full_adder_bit u_fa (
    .a (a_sh_q[0]),
    .b (b_sh_q[0]),
    .ci(carry_q),
    .s (fa_s),
    .co(fa_co)
  );

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == SHIFT);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    count_d  = count_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          count_d = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        carry_d         = fa_co;
        a_sh_d          = a_sh_q >> 1;
        b_sh_d          = b_sh_q >> 1;
        sum_sh_d        = sum_sh_q >> 1;
        sum_sh_d[W-1]   = fa_s;
        count_d         = count_q + CW'(1);
        if (count_q == LAST) begin
          // Publish on the last shift so sum/cout hold until the next DONE.
          sum_d   = sum_sh_d;
          cout_d  = fa_co;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed table plus corner sequences and full sweep.
// Ports: none (testbench).
module tb_serial_adder;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int checks = 0;
  int errors = 0;

  serial_adder #(.W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    int           stall;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Runs one operation; all driving and sampling on negedges.
  task automatic do_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic vc, input int stall, input bit intrude,
                       output logic [W-1:0] rs, output logic rc);
    int lat;
    logic [W-1:0] hs;
    logic hc;
    rs = '0;
    rc = 1'b0;
    check("in_ready_before", in_ready, 1);
    in_valid  = 1'b1;
    a         = va;
    b         = vb;
    cin       = vc;
    out_ready = (stall == 0);
    @(posedge clk);
    @(negedge clk);
    if (intrude) begin
      a   = 4'd7;
      b   = 4'd7;
      cin = 1'b0;
    end else begin
      in_valid = 1'b0;
      a        = ~va;
      b        = ~vb;
      cin      = ~vc;
    end
    lat = 1;
    while (!out_valid && lat < 20) begin
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
        check("shift_flags", {in_ready, busy}, 2'b01);
      end
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    if (!out_valid) begin
      check("timeout", 0, 1);
      return;
    end
    check("latency", lat - 1, W);
    check("in_ready_done", in_ready, 0);
    hs = sum;
    hc = cout;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid !== 1'b1 || sum !== hs || cout !== hc)
        check("hold", {out_valid, cout, sum}, {1'b1, hc, hs});
      if (i == stall - 1) out_ready = 1'b1;
    end
    rs = sum;
    rc = cout;
    @(posedge clk);
    @(negedge clk);
    check("one_pulse", out_valid, 0);
    check("idle_ready", in_ready, 1);
    out_ready = 1'b0;
  endtask

  vec_t vecs[5];
  logic [W-1:0] rs;
  logic rc;
  int n_res;

  initial begin
    vecs[0] = '{4'd0,  4'd0,  1'b0, 0, 4'b0000, 1'b0};
    vecs[1] = '{4'd5,  4'd3,  1'b0, 0, 4'b1000, 1'b0};
    vecs[2] = '{4'd15, 4'd1,  1'b0, 0, 4'b0000, 1'b1};
    vecs[3] = '{4'd15, 4'd15, 1'b1, 0, 4'b1111, 1'b1};
    vecs[4] = '{4'd9,  4'd6,  1'b1, 3, 4'b0000, 1'b1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", {cout, sum}, 0);

    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].stall, 1'b0, rs, rc);
      check($sformatf("vec%0d", i), {rc, rs},
            {vecs[i].exp_cout, vecs[i].exp_sum});
    end

    // Request during SHIFT must be ignored.
    do_op(4'd1, 4'd2, 1'b0, 0, 1'b1, rs, rc);
    check("intrude_res", {rc, rs}, 5'b00011);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("no_extra", {out_valid, busy}, 2'b00);
    end

    // Reset in the 2nd SHIFT cycle aborts the operation.
    in_valid = 1'b1;
    a        = 4'd12;
    b        = 4'd12;
    cin      = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_flags", {in_ready, out_valid, busy}, 3'b100);
    check("abort_sum", {cout, sum}, 0);
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) check("abort_leak", out_valid, 0);
    end
    do_op(4'd2, 4'd2, 1'b0, 0, 1'b0, rs, rc);
    check("after_abort", {rc, rs}, 5'b00100);

    // Exhaustive sweep with random consumer stalls.
    n_res = 0;
    for (int i = 0; i < 512; i++) begin
      logic [W-1:0] va;
      logic [W-1:0] vb;
      logic vc;
      logic [4:0] exp;
      va  = i[3:0];
      vb  = i[7:4];
      vc  = i[8];
      exp = {1'b0, va} + {1'b0, vb} + {4'b0, vc};
      do_op(va, vb, vc, int'($urandom_range(0, 2)), 1'b0, rs, rc);
      if (out_valid === 1'b0) n_res++;
      if ({rc, rs} !== exp) check("sweep", {rc, rs}, exp);
    end
    check("sweep_count", n_res, 512);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
